// File: rtl/road_scroll_if.sv
// ---------------------------------------------------------------------------
// road_scroll_if
// Bundles the pixel-position inputs, control inputs and colour/status
// outputs of the lane-marker scroll generator.
//   pix_row     10  current pixel row from the display timing generator
//   pix_col     10  current pixel column from the display timing generator
//   level        2  difficulty level, selects the scroll divider
//   pause        1  freeze scrolling while high
//   road_out    12  registered road/lane colour for the pixel (1 clk latency)
//   scroll_tick  1  one-cycle pulse per scroll step
//   distance    16  saturating count of scroll steps since reset
// master: the side driving pixel position and controls (timing gen / bench)
// slave : the scroll generator itself
// ---------------------------------------------------------------------------
interface road_scroll_if;
    logic [9:0]  pix_row;
    logic [9:0]  pix_col;
    logic [1:0]  level;
    logic        pause;
    logic [11:0] road_out;
    logic        scroll_tick;
    logic [15:0] distance;

    modport master (
        output pix_row, pix_col, level, pause,
        input  road_out, scroll_tick, distance
    );

    modport slave (
        input  pix_row, pix_col, level, pause,
        output road_out, scroll_tick, distance
    );
endinterface

// File: rtl/road_scroll_gen.sv
// ---------------------------------------------------------------------------
// road_scroll_gen
// Lane-marker scroll generator for the racing display. Produces the 12-bit
// colour of the current pixel (asphalt, grass or dashed lane line) and
// scrolls the dashes down the screen at a level-dependent rate.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of road_scroll_if (pixel position, level, pause in;
//          road_out, scroll_tick, distance out)
// ---------------------------------------------------------------------------
module road_scroll_gen #(
    parameter int          CLK_HZ           = 100000000,
    parameter int          TICK_HZ          = 500,
    parameter int          SCREEN_H         = 480,
    parameter int          NUM_LINES        = 2,
    parameter int          LINE_COL0        = 255,
    parameter int          LANE_PITCH       = 128,
    parameter int          LINE_W           = 4,
    parameter int          ROAD_L           = 128,
    parameter int          ROAD_R           = 511,
    parameter int          DASH_PERIOD_LOG2 = 7,
    parameter int          DASH_LEN         = 48,
    parameter int          STEP             = 8,
    parameter int          DIV_L0           = 8,
    parameter int          DIV_L1           = 6,
    parameter int          DIV_L2           = 4,
    parameter int          DIV_L3           = 2,
    parameter logic [11:0] LINE_COLOR       = 12'hFFF,
    parameter logic [11:0] ROAD_COLOR       = 12'h444,
    parameter logic [11:0] GRASS_COLOR      = 12'h0A0
) (
    input  logic clk,
    input  logic reset,
    road_scroll_if.slave bus
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int OFF_W    = DASH_PERIOD_LOG2;

    logic [PRE_W-1:0] prescaler;
    logic             base_tick;
    logic [15:0]      divider;
    logic [15:0]      divider_next;
    logic [15:0]      div_sel;
    logic             tick_next;
    logic [1:0]       level_q;
    logic             scroll_tick_q;
    logic [OFF_W-1:0] pending_off;
    logic [OFF_W-1:0] disp_off;
    logic [OFF_W-1:0] phase;
    logic [15:0]      distance_q;
    logic             in_line;
    logic             row_blank;
    logic [11:0]      color_next;
    logic [11:0]      road_q;
    int               col_i;

    // Base tick prescaler: free-running, never paused, so the scroll cadence
    // keeps its phase across pause and level changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (base_tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign base_tick = (prescaler == PRE_W'(PRESCALE - 1));

    // Divider ratio for the currently registered level.
    always_comb begin
        div_sel = 16'(DIV_L0);
        case (level_q)
            2'd0:    div_sel = 16'(DIV_L0);
            2'd1:    div_sel = 16'(DIV_L1);
            2'd2:    div_sel = 16'(DIV_L2);
            default: div_sel = 16'(DIV_L3);
        endcase
    end

    // A level change restarts the divider so the new rate begins with a full
    // period; otherwise count unpaused base ticks and emit a step on wrap.
    always_comb begin
        divider_next = divider;
        tick_next    = 1'b0;
        if (bus.level != level_q) begin
            divider_next = '0;
        end else if (base_tick && !bus.pause) begin
            if (divider >= div_sel - 16'd1) begin
                divider_next = '0;
                tick_next    = 1'b1;
            end else begin
                divider_next = divider + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider       <= '0;
            level_q       <= '0;
            scroll_tick_q <= 1'b0;
        end else begin
            divider       <= divider_next;
            level_q       <= bus.level;
            scroll_tick_q <= tick_next;
        end
    end

    // Each scroll step advances the pending offset (wrapping within one dash
    // period) and bumps the saturating odometer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_off <= '0;
            distance_q  <= '0;
        end else if (scroll_tick_q) begin
            pending_off <= pending_off + OFF_W'(STEP);
            if (distance_q != 16'hFFFF) begin
                distance_q <= distance_q + 16'd1;
            end
        end
    end

    assign row_blank = (bus.pix_row >= 10'(SCREEN_H));

    // The displayed offset only follows the pending one during vertical
    // blank, so a frame is always drawn with a single offset (no tearing).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_off <= '0;
        end else if (row_blank) begin
            disp_off <= pending_off;
        end
    end

    // Pixel classification. Subtracting the offset moves dashes toward
    // higher rows as the offset grows; truncation gives the seamless wrap.
    always_comb begin
        col_i      = int'(bus.pix_col);
        phase      = bus.pix_row[OFF_W-1:0] - disp_off;
        in_line    = 1'b0;
        color_next = GRASS_COLOR;
        for (int k = 0; k < NUM_LINES; k++) begin
            if (col_i >= LINE_COL0 + k * LANE_PITCH &&
                col_i <= LINE_COL0 + k * LANE_PITCH + LINE_W - 1) begin
                in_line = 1'b1;
            end
        end
        if (row_blank) begin
            color_next = 12'h000;
        end else if (in_line && (phase < OFF_W'(DASH_LEN))) begin
            color_next = LINE_COLOR;
        end else if (col_i >= ROAD_L && col_i <= ROAD_R) begin
            color_next = ROAD_COLOR;
        end else begin
            color_next = GRASS_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            road_q <= '0;
        end else begin
            road_q <= color_next;
        end
    end

    assign bus.road_out    = road_q;
    assign bus.scroll_tick = scroll_tick_q;
    assign bus.distance    = distance_q;

endmodule

// File: doc/road_scroll_gen.md
Name: road_scroll_gen

Overview:
Parametrised lane-marker scroll generator for the racing display. Produces the 12-bit road/lane-line colour for the current pixel (pix_row, pix_col) from the display timing generator. Generalises the fixed six-dash, two-line road to N lane lines with configurable dash geometry, per-level scroll rate, pause, tear-free frame-synchronous offset commit and a distance odometer. Sits between the display timing generator and the sprite/car colour mux.

Parameters:
CLK_HZ, 100000000, system clock frequency
TICK_HZ, 500, base scroll tick rate
SCREEN_H, 480, visible rows; rows >= SCREEN_H are vertical blank
NUM_LINES, 2, lane lines drawn, 1..8
LINE_COL0, 255, first column of lane line 0
LANE_PITCH, 128, column spacing between lane lines
LINE_W, 4, lane line width in columns
ROAD_L, 128, first road column (inclusive)
ROAD_R, 511, last road column (inclusive)
DASH_PERIOD_LOG2, 7, dash period = 2^DASH_PERIOD_LOG2 rows
DASH_LEN, 48, painted rows per period; must be < 2^DASH_PERIOD_LOG2
STEP, 8, rows advanced per scroll tick
DIV_L0/DIV_L1/DIV_L2/DIV_L3, 8/6/4/2, base ticks per scroll tick for level 0..3 (each >= 1)
LINE_COLOR, 12'hFFF, dash colour
ROAD_COLOR, 12'h444, asphalt colour
GRASS_COLOR, 12'h0A0, off-road colour

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
pix_row  in  10  current pixel row
pix_col  in  10  current pixel column
level  in  2  difficulty level; selects DIV_Lx
pause  in  1  freeze scrolling when 1
road_out  out  12  pixel colour, 1-cycle latency
scroll_tick  out  1  one-cycle pulse per scroll step
distance  out  16  scroll steps since reset, saturating

Behaviour:
- Reset (async assert, sync deassert by design): prescaler=0, divider=0, pending_off=0, disp_off=0, road_out=0, scroll_tick=0, distance=0, level_q=0.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1, base_tick pulses one cycle at terminal count, then wraps to 0. Runs regardless of pause.
- Divider: on base_tick with pause=0, increments; when it reaches DIV_L[level]-1 it clears and asserts scroll_tick next cycle. Exactly DIV_L[level] base ticks per scroll tick.
- Level change: level registered into level_q; when level != level_q, divider clears that cycle (no tick emitted). Prescaler unaffected.
- pause=1: divider holds, no scroll_tick, pending_off and distance hold. Deassert resumes from held divider value.
- On scroll_tick: pending_off <= (pending_off + STEP) mod 2^DASH_PERIOD_LOG2 (natural wrap, width DASH_PERIOD_LOG2). distance increments, saturates at 16'hFFFF.
- Frame-sync commit: disp_off <= pending_off on every cycle with pix_row >= SCREEN_H; during visible rows disp_off holds. No mid-frame tearing. Scroll tick coinciding with blank: the new pending_off is committed on the following cycle, if that cycle is still in blank.
- Pixel path (registered, latency 1 clk):
  - phase = (pix_row - disp_off) truncated to DASH_PERIOD_LOG2 bits.
  - in_line = for some k < NUM_LINES: LINE_COL0 + k*LANE_PITCH <= pix_col <= LINE_COL0 + k*LANE_PITCH + LINE_W - 1.
  - road_out = LINE_COLOR if in_line and phase < DASH_LEN. Otherwise ROAD_COLOR if ROAD_L <= pix_col <= ROAD_R. Otherwise GRASS_COLOR.
  - pix_row >= SCREEN_H: road_out = 12'h000.
- Increasing offset moves dashes down the screen (toward higher rows). Dashes wrap seamlessly across the period boundary and across the screen bottom.
- Lines whose columns exceed ROAD_R are still drawn; placement is the integrator's responsibility.

Test Plan:
- Reset mid-run (CLK_HZ=1000, TICK_HZ=100, level=3): assert reset with pending_off=40, distance=5 -> all outputs 0 immediately (async), first scroll_tick 20 clk after deassert +1.
- Rate per level (same params): level=0 -> scroll_tick every 80 clk; level=2 -> every 40 clk; switch level mid-count -> divider restarts, next tick one full new period later.
- Wrap: DASH_PERIOD_LOG2=7, STEP=8, 16 scroll ticks from 0 -> pending_off 0x78 then 0x00; distance=16.
- Pixel colours at disp_off=0, level 0: (row 10, col 256) -> 12'hFFF; (row 60, col 256) -> 12'h444; (row 10, col 100) -> 12'h0A0; (row 10, col 384) -> 12'hFFF; (row 490, any col) -> 12'h000; each appears 1 clk after the inputs.
- Tear-free commit: scroll_tick while pix_row=200 -> colour at (row 300, col 256) unchanged until pix_row >= 480; after blank, disp_off=8 and row 50 (phase 42) -> 12'hFFF.
- Pause/saturation: pause=1 for 500 clk -> no scroll_tick, offset/distance frozen. Preload distance near max (force 16'hFFFE), 3 scroll ticks -> distance stays 16'hFFFF.
